// File: rtl/sig_capture_buffer.sv
// sig_capture_buffer: triggered DEPTH-sample capture buffer with read port; SIG_CAPTURE_TIMESTAMP_EN adds trigger timestamping
module sig_capture_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sig_data,
  input  logic              sig_valid,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        state,
  output logic              done,
  output logic [31:0]       trig_ts
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, CAPTURE = 2'b10, DONE = 2'b11} state_t;
  state_t st, st_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_addr;
  logic [DATA_W-1:0] prev;
  logic prev_valid, crossing, trig, wr_en, last, arm_ok;
  logic [DATA_W-1:0] mem [DEPTH];
  assign state = st;
  assign done = st == DONE;
  // trigger detection, write qualification and next state
  always_comb begin
    crossing = prev_valid && ($signed(prev) < $signed(trig_level)) && ($signed(sig_data) >= $signed(trig_level));
    arm_ok = arm && (st == IDLE || st == DONE);
    trig = st == ARMED && sig_valid && (force_trig || crossing);
    wr_en = trig || (st == CAPTURE && sig_valid);
    wr_addr = trig ? '0 : wr_ptr;
    last = st == CAPTURE && sig_valid && (&wr_ptr);
    st_nxt = arm_ok ? ARMED : trig ? CAPTURE : last ? DONE : st;
  end
  // state, write pointer, crossing history and registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      wr_ptr <= '0;
      prev <= '0;
      prev_valid <= 1'b0;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      st <= st_nxt;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
      if (arm_ok) begin
        wr_ptr <= '0;
        prev_valid <= 1'b0;
      end else begin
        if (wr_en && !last) wr_ptr <= wr_addr + 1'b1;
        if (st == ARMED && sig_valid) begin
          prev <= sig_data;
          prev_valid <= 1'b1;
        end
      end
    end
  end
  // sample buffer write port; read-first because the read above sees the pre-edge contents
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= sig_data;
  end
`ifdef SIG_CAPTURE_TIMESTAMP_EN
  logic [31:0] cnt;
  // free-running cycle counter and trigger timestamp latch
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      trig_ts <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      if (trig) trig_ts <= cnt;
    end
  end
`else
  assign trig_ts = '0;
`endif
endmodule

// File: tb/tb_sig_capture_buffer.sv
// tb_sig_capture_buffer: randomized self-checking bench for sig_capture_buffer against a sample-list model
module tb_sig_capture_buffer;
  localparam int DEPTH = 1024;
`ifdef SIG_CAPTURE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] sig_data = '0;
  logic sig_valid = 1'b0;
  logic arm = 1'b0;
  logic force_trig = 1'b0;
  logic [15:0] trig_level = '0;
  logic rd_en = 1'b0;
  logic [9:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic rd_valid;
  logic [1:0] state;
  logic done;
  logic [31:0] trig_ts;
  int n_pass = 0;
  int n_total = 0;
  logic [15:0] vq[$];
  int cq[$];
  bit fq[$];
  logic [15:0] rb [DEPTH];
  int rv_cnt;
  logic post_rv;
  logic [15:0] post_rd;
  logic [1:0] st1;
  int rf_k = -1;
  logic [15:0] rf_data;
  logic rf_valid;

  always #5 clk = ~clk;

  sig_capture_buffer dut (
    .clk(clk), .rst(rst), .sig_data(sig_data), .sig_valid(sig_valid), .arm(arm),
    .force_trig(force_trig), .trig_level(trig_level), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .state(state), .done(done), .trig_ts(trig_ts)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int find_trig();
    for (int i = 0; i < vq.size(); i++)
      if (fq[i] || (i > 0 && $signed(vq[i-1]) < $signed(trig_level) && $signed(vq[i]) >= $signed(trig_level)))
        return i;
    return -1;
  endfunction

  function automatic int exp_done(input int ti);
    return (ti >= 0 && ti + DEPTH - 1 < vq.size()) ? cq[ti+DEPTH-1] + 1 : -2;
  endfunction

  function automatic int img_bad(input int ti);
    int b = 0;
    for (int j = 0; j < DEPTH; j++)
      if (ti < 0 || ti + j >= vq.size() || rb[j] !== vq[ti+j]) b++;
    return b;
  endfunction

  task automatic run_capture(input int mode, input int budget, output int dc);
    logic [15:0] d;
    logic v, f;
    vq.delete();
    cq.delete();
    fq.delete();
    @(negedge clk);
    arm = 1'b1;
    sig_valid = 1'b0;
    force_trig = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    dc = -1;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        dc = k;
        break;
      end
      if (k == 1) st1 = state;
      if (k == rf_k + 1) begin
        rf_data = rd_data;
        rf_valid = rd_valid;
      end
      f = 1'b0;
      if (mode == 0) begin
        v = 1'b1;
        d = 16'hFF00 + 16'(k);
      end else if (mode == 1) begin
        v = (k % 2 == 0);
        d = v ? 16'hFF00 + 16'(k / 2) : 16'($urandom);
      end else if (mode == 2) begin
        v = 1'b1;
        d = 16'h7FFF;
        f = 1'b1;
      end else if (mode == 3) begin
        v = ($urandom_range(0, 3) != 0);
        d = 16'($urandom);
      end else begin
        v = 1'b1;
        d = 16'hBADC;
        f = 1'b1;
      end
      sig_valid = v;
      sig_data = d;
      force_trig = f;
      rd_en = (k == rf_k);
      rd_addr = 10'(rf_k);
      if (v) begin
        vq.push_back(d);
        cq.push_back(k);
        fq.push_back(f);
      end
      @(negedge clk);
    end
    sig_valid = 1'b0;
    force_trig = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic read_all();
    rv_cnt = 0;
    for (int a = 0; a <= DEPTH; a++) begin
      @(negedge clk);
      if (a > 0) begin
        rb[a-1] = rd_data;
        if (rd_valid === 1'b1) rv_cnt++;
      end
      rd_en = (a < DEPTH);
      rd_addr = 10'(a);
    end
    @(negedge clk);
    post_rv = rd_valid;
    post_rd = rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sig_data = 16'($urandom);
      sig_valid = 1'($urandom);
      arm = 1'($urandom);
      force_trig = 1'($urandom);
      trig_level = 16'($urandom);
      rd_en = 1'($urandom);
      rd_addr = 10'($urandom);
    end
    @(negedge clk);
    n_total++; if (state !== 2'b00) $display("FAIL reset_state: got %b want 00", state); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else n_pass++;
    n_total++; if (rd_data !== 16'h0) $display("FAIL reset_rd_data: got %h want 0000", rd_data); else n_pass++;
    n_total++; if (trig_ts !== 32'h0) $display("FAIL reset_trig_ts: got %h want 0", trig_ts); else n_pass++;
    rst = 1'b0;
    sig_valid = 1'b0;
    arm = 1'b0;
    force_trig = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_crossing();
    int dc, ti, dl;
    trig_level = 16'h0010;
    run_capture(0, 3000, dc);
    ti = find_trig();
    dl = (ti >= 0) ? dc - cq[ti] : -1;
    n_total++; if (st1 !== 2'b01) $display("FAIL cross_armed: got %b want 01", st1); else n_pass++;
    n_total++; if (dc !== exp_done(ti)) $display("FAIL cross_done_cycle: got %0d want %0d", dc, exp_done(ti)); else n_pass++;
    n_total++; if (dl !== 1024) $display("FAIL cross_done_delay: got %0d want 1024", dl); else n_pass++;
    n_total++; if (state !== 2'b11 || done !== 1'b1) $display("FAIL cross_final: got state %b done %b want 11 1", state, done); else n_pass++;
    read_all();
    n_total++; if (img_bad(ti) !== 0) $display("FAIL cross_image: got %0d bad entries want 0", img_bad(ti)); else n_pass++;
    n_total++; if (rb[0] !== 16'h0010) $display("FAIL cross_mem0: got %h want 0010", rb[0]); else n_pass++;
    n_total++; if (rb[1023] !== 16'h040F) $display("FAIL cross_mem1023: got %h want 040f", rb[1023]); else n_pass++;
    n_total++; if (rv_cnt !== DEPTH) $display("FAIL cross_rd_valid_count: got %0d want %0d", rv_cnt, DEPTH); else n_pass++;
    n_total++; if (post_rv !== 1'b0) $display("FAIL cross_rd_valid_idle: got %b want 0", post_rv); else n_pass++;
    n_total++; if (post_rd !== 16'h040F) $display("FAIL cross_rd_hold: got %h want 040f", post_rd); else n_pass++;
  endtask

  task automatic test_gaps();
    int dc, ti, dl;
    trig_level = 16'h0010;
    run_capture(1, 5000, dc);
    ti = find_trig();
    dl = (ti >= 0) ? dc - cq[ti] : -1;
    n_total++; if (dc !== exp_done(ti)) $display("FAIL gaps_done_cycle: got %0d want %0d", dc, exp_done(ti)); else n_pass++;
    n_total++; if (dl !== 2047) $display("FAIL gaps_done_delay: got %0d want 2047", dl); else n_pass++;
    read_all();
    n_total++; if (img_bad(ti) !== 0) $display("FAIL gaps_image: got %0d bad entries want 0", img_bad(ti)); else n_pass++;
    n_total++; if (rb[0] !== 16'h0010 || rb[1023] !== 16'h040F) $display("FAIL gaps_ends: got %h %h want 0010 040f", rb[0], rb[1023]); else n_pass++;
  endtask

  task automatic test_force();
    int dc, bad;
    trig_level = 16'h7FFF;
    run_capture(2, 3000, dc);
    n_total++; if (dc !== 1024) $display("FAIL force_done_cycle: got %0d want 1024", dc); else n_pass++;
    read_all();
    bad = 0;
    for (int j = 0; j < DEPTH; j++) if (rb[j] !== 16'h7FFF) bad++;
    n_total++; if (bad !== 0) $display("FAIL force_image: got %0d entries not 7fff want 0", bad); else n_pass++;
  endtask

  task automatic test_read_first();
    int dc, bad, k;
    k = $urandom_range(1, 1000);
    rf_k = k;
    run_capture(4, 3000, dc);
    rf_k = -1;
    n_total++; if (rf_valid !== 1'b1 || rf_data !== 16'h7FFF) $display("FAIL read_first: got valid %b data %h want 1 7fff", rf_valid, rf_data); else n_pass++;
    read_all();
    n_total++; if (rb[k] !== 16'hBADC) $display("FAIL read_after_write: got %h want badc", rb[k]); else n_pass++;
    bad = 0;
    for (int j = 0; j < DEPTH; j++) if (rb[j] !== 16'hBADC) bad++;
    n_total++; if (bad !== 0) $display("FAIL sentinel_image: got %0d entries not badc want 0", bad); else n_pass++;
  endtask

  task automatic test_random_capture();
    int dc, ti;
    trig_level = 16'($urandom_range(0, 16383)) - 16'h2000;
    run_capture(3, 8000, dc);
    ti = find_trig();
    n_total++; if (dc !== exp_done(ti)) $display("FAIL rand_done_cycle: got %0d want %0d", dc, exp_done(ti)); else n_pass++;
    read_all();
    n_total++; if (img_bad(ti) !== 0) $display("FAIL rand_image: got %0d bad entries want 0", img_bad(ti)); else n_pass++;
  endtask

  task automatic test_abort();
    int dc, ti;
    trig_level = 16'h0000;
    @(negedge clk);
    arm = 1'b1;
    sig_valid = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    for (int k = 0; k <= 500; k++) begin
      if (k == 101) begin
        n_total++; if (state !== 2'b10 || done !== 1'b0) $display("FAIL abort_arm_ignored: got state %b done %b want 10 0", state, done); else n_pass++;
      end
      sig_valid = 1'b1;
      force_trig = 1'b1;
      sig_data = 16'(k);
      arm = (k == 100);
      rst = (k == 500);
      @(negedge clk);
    end
    n_total++; if (state !== 2'b00 || done !== 1'b0) $display("FAIL abort_reset: got state %b done %b want 00 0", state, done); else n_pass++;
    rst = 1'b0;
    arm = 1'b0;
    repeat (20) @(negedge clk);
    n_total++; if (state !== 2'b00 || done !== 1'b0) $display("FAIL abort_hold: got state %b done %b want 00 0", state, done); else n_pass++;
    sig_valid = 1'b0;
    force_trig = 1'b0;
    trig_level = 16'h0010;
    run_capture(0, 3000, dc);
    ti = find_trig();
    n_total++; if (dc !== exp_done(ti)) $display("FAIL rearm_done_cycle: got %0d want %0d", dc, exp_done(ti)); else n_pass++;
    read_all();
    n_total++; if (img_bad(ti) !== 0) $display("FAIL rearm_image: got %0d bad entries want 0", img_bad(ti)); else n_pass++;
  endtask

  task automatic test_timestamp();
    logic [31:0] want;
    want = TS_EN ? 32'd5000 : 32'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 5000; n++) begin
      @(negedge clk);
      if (n == 10) begin
        n_total++; if (trig_ts !== 32'd0) $display("FAIL ts_before: got %0d want 0", trig_ts); else n_pass++;
      end
      arm = (n == 4999);
      sig_valid = (n == 5000);
      force_trig = (n == 5000);
      sig_data = 16'($urandom);
    end
    @(negedge clk);
    arm = 1'b0;
    sig_valid = 1'b0;
    force_trig = 1'b0;
    n_total++; if (state !== 2'b10) $display("FAIL ts_state: got %b want 10", state); else n_pass++;
    n_total++; if (trig_ts !== want) $display("FAIL ts_value: got %0d want %0d", trig_ts, want); else n_pass++;
    repeat (50) @(negedge clk);
    n_total++; if (trig_ts !== want) $display("FAIL ts_hold: got %0d want %0d", trig_ts, want); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_crossing();
    test_gaps();
    test_force();
    test_read_first();
    test_random_capture();
    test_random_capture();
    test_abort();
    test_timestamp();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
